voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
- Owns the voice table for the time-multiplexed phase bank.
- Accepts note-on/off events over a valid/ready handshake and allocates them to NBANKS voice slots, stealing a slot when the table is full.
- On each sample tick it sequences one frame: exactly NBANKS clock-enable strobes, each carrying the MIDI note of the matching slot.
- Its outputs drive the phase bank's clk_en and i_midi inputs directly.

Parameters:
- NBANKS, 10, number of voice slots; must equal the phase bank's bank count.
- SW, 4, slot index width; must satisfy 2^SW >= NBANKS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- i_tick  in  1  sample-rate strobe, one cycle wide.
- i_ev_valid  in  1  note event valid.
- i_ev_on  in  1  1 = note-on, 0 = note-off.
- i_ev_note  in  7  MIDI note number.
- o_ev_ready  out  1  event accepted when i_ev_valid && o_ev_ready.
- o_clk_en  out  1  phase-bank advance strobe.
- o_midi  out  7  note for the current slot; 0 = slot idle.
- o_slot  out  SW  slot index presented with o_clk_en.
- o_active  out  NBANKS  bit i set when slot i holds a note.
- o_overrun  out  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset (synchronous, any state, including mid-frame or mid-search):
  - All outputs 0.
  - Voice table cleared to 0; tick_pending 0; steal pointer 0; state IDLE.
  - Slot pointer set to NBANKS-1, matching the phase bank's bank pointer after reset.
- Slot pointer:
  - Advances mod NBANKS on every cycle o_clk_en is high, and at no other time.
  - A frame issues exactly NBANKS strobes, so bank alignment is preserved. After reset the frame order is NBANKS-1, 0, 1, …, NBANKS-2.
- FSM states: IDLE, SEARCH, COMMIT, SCAN.
- IDLE:
  - If i_tick or tick_pending: go to SCAN and clear tick_pending. Ticks take priority over events.
  - Else if i_ev_valid: capture the event, go to SEARCH.
  - o_ev_ready = (state==IDLE) && !i_tick && !tick_pending (combinational).
- SEARCH:
  - Takes NBANKS cycles and examines one slot per cycle, index 0 upward.
  - Records the first slot whose note equals the captured note (match) and the lowest-index slot holding 0 (free).
- COMMIT (1 cycle), then IDLE:
  - Note-on, match found: no change (retrigger ignored).
  - Note-on, no match, free found: write note into the free slot.
  - Note-on, no match, no free slot: write into the slot at the steal pointer, then increment the steal pointer mod NBANKS.
  - Note-off, match found: write 0 to that slot.
  - Note-off, no match: no change.
  - Any event with note 0: no change (0 is the idle code).
- SCAN:
  - Runs NBANKS cycles.
  - Each cycle: o_clk_en=1, o_slot=slot pointer, o_midi=table[slot pointer]. All three are registered and change together.
  - After the last strobe, return to IDLE.
  - o_clk_en is 0 in every other state; o_midi and o_slot hold their last values.
- Tick latency: i_tick seen in IDLE at cycle T gives strobes on cycles T+1 … T+NBANKS.
- Event latency: handshake at cycle T gives the table updated and o_active valid at T+NBANKS+2; o_ev_ready is low from T+1 through T+NBANKS+1.
- Tick during SEARCH or COMMIT:
  - Sets tick_pending.
  - If tick_pending is already set, pulse o_overrun and drop the tick.
- Tick during SCAN: pulse o_overrun on the next cycle; the tick is dropped and the frame is not extended.
- Table writes occur only in COMMIT, never during SCAN, so a frame always sees a consistent table.
- o_active is registered from the table (bit i = table[i]!=0) and updates the cycle after COMMIT.

Test Plan:
- Reset, then one i_tick → 10 strobes with o_slot 9,0,1,…,8; o_midi=0 throughout; o_active=0.
- Note-on 0x45, then tick → o_active=0x001; o_midi=0x45 only when o_slot=0. Note-off 0x45 → o_active=0x000.
- Note-on 0x3C twice → a single slot is used, o_active=0x001. Note-off 0x40 (not held) → table unchanged.
- Note-on 0x30…0x39 (10 notes, table full), then 0x50 → slot 0 overwritten with 0x50; then 0x51 → slot 1 overwritten (steal pointer advanced).
- i_tick asserted on the cycle after an event handshake → strobes begin the cycle after COMMIT, o_overrun stays 0; a second tick during that same SEARCH → o_overrun pulses once.
- i_tick during SCAN → o_overrun pulses once, frame still 10 strobes; rst asserted mid-SCAN → next cycle o_clk_en=0, o_active=0, and the next frame starts at o_slot=9.

Source files
------------

// File: rtl/voice_scheduler.sv
// Voice table owner for the time-multiplexed phase bank: allocates note events
// to slots and emits one frame of per-slot clock-enable strobes per sample tick.
module voice_scheduler #(
  parameter int NBANKS = 10,
  parameter int SW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_ev_valid,
  input  logic              i_ev_on,
  input  logic [6:0]        i_ev_note,
  output logic              o_ev_ready,
  output logic              o_clk_en,
  output logic [6:0]        o_midi,
  output logic [SW-1:0]     o_slot,
  output logic [NBANKS-1:0] o_active,
  output logic              o_overrun
);

  localparam logic [SW-1:0] LAST = SW'(NBANKS - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, COMMIT, SCAN} state_t;

  state_t          r_state;
  logic [6:0]      r_table [NBANKS];
  logic            r_tick_pending;
  logic [SW-1:0]   r_ptr;
  logic [SW-1:0]   r_steal;
  logic [SW-1:0]   r_idx;
  logic [SW-1:0]   r_cnt;
  logic            r_on;
  logic [6:0]      r_note;
  logic            r_match_found;
  logic [SW-1:0]   r_match_idx;
  logic            r_free_found;
  logic [SW-1:0]   r_free_idx;
  logic            r_clk_en;
  logic [6:0]      r_midi;
  logic [SW-1:0]   r_slot;
  logic            r_overrun;
  logic [NBANKS-1:0] r_active;

  logic [6:0]      w_entry;
  logic            w_we;
  logic [SW-1:0]   w_waddr;
  logic [6:0]      w_wdata;
  logic            w_steal;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  assign w_entry    = r_table[r_idx];
  assign o_ev_ready = (r_state == IDLE) && !i_tick && !r_tick_pending;
  assign o_clk_en   = r_clk_en;
  assign o_midi     = r_midi;
  assign o_slot     = r_slot;
  assign o_overrun  = r_overrun;
  assign o_active   = r_active;

  // Commit decision: note 0 is the idle code and never touches the table.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    w_steal = 1'b0;
    if (r_state == COMMIT && r_note != 7'd0) begin
      if (r_on) begin
        if (!r_match_found) begin
          w_we    = 1'b1;
          w_wdata = r_note;
          w_waddr = r_free_found ? r_free_idx : r_steal;
          w_steal = !r_free_found;
        end
      end else if (r_match_found) begin
        w_we    = 1'b1;
        w_waddr = r_match_idx;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          r_table[gi]  <= '0;
          r_active[gi] <= 1'b0;
        end else if (w_we && w_waddr == SW'(gi)) begin
          r_table[gi]  <= w_wdata;
          r_active[gi] <= (w_wdata != 7'd0);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_tick_pending <= 1'b0;
      r_ptr          <= LAST;
      r_steal        <= '0;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_on           <= 1'b0;
      r_note         <= '0;
      r_match_found  <= 1'b0;
      r_match_idx    <= '0;
      r_free_found   <= 1'b0;
      r_free_idx     <= '0;
      r_clk_en       <= 1'b0;
      r_midi         <= '0;
      r_slot         <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_clk_en  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_tick || r_tick_pending) begin
            r_tick_pending <= 1'b0;
            r_clk_en       <= 1'b1;
            r_slot         <= r_ptr;
            r_midi         <= r_table[r_ptr];
            r_ptr          <= wrap_inc(r_ptr);
            r_cnt          <= '0;
            r_state        <= SCAN;
          end else if (i_ev_valid) begin
            r_on          <= i_ev_on;
            r_note        <= i_ev_note;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_state       <= SEARCH;
          end
        end
        SEARCH: begin
          if (!r_match_found && w_entry == r_note) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (!r_free_found && w_entry == 7'd0) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          if (i_tick) begin
            if (r_tick_pending) r_overrun <= 1'b1;
            r_tick_pending <= 1'b1;
          end
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) r_state <= COMMIT;
        end
        COMMIT: begin
          if (w_steal) r_steal <= wrap_inc(r_steal);
          if (i_tick) begin
            if (r_tick_pending) r_overrun <= 1'b1;
            r_tick_pending <= 1'b1;
          end
          r_state <= IDLE;
        end
        SCAN: begin
          // Ticks arriving mid-frame are dropped; the frame length never changes.
          if (i_tick) r_overrun <= 1'b1;
          if (r_cnt == LAST) begin
            r_state <= IDLE;
          end else begin
            r_clk_en <= 1'b1;
            r_slot   <= r_ptr;
            r_midi   <= r_table[r_ptr];
            r_ptr    <= wrap_inc(r_ptr);
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, stealing, frame sequencing,
// tick collisions and mid-frame reset.
module tb_voice_scheduler;
  localparam int NB = 10;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_tick;
  logic          i_ev_valid;
  logic          i_ev_on;
  logic [6:0]    i_ev_note;
  logic          o_ev_ready;
  logic          o_clk_en;
  logic [6:0]    o_midi;
  logic [SW-1:0] o_slot;
  logic [NB-1:0] o_active;
  logic          o_overrun;

  int checks = 0;
  int errors = 0;

  int         f_count;
  int         f_order [16];
  logic [6:0] f_midi  [16];

  voice_scheduler #(.NBANKS(NB), .SW(SW)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_ev_valid(i_ev_valid),
    .i_ev_on(i_ev_on), .i_ev_note(i_ev_note), .o_ev_ready(o_ev_ready),
    .o_clk_en(o_clk_en), .o_midi(o_midi), .o_slot(o_slot),
    .o_active(o_active), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic wait_ready();
    int n = 0;
    while (!o_ev_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!o_ev_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: o_ev_ready=%0b required 1", o_ev_ready);
    end
  endtask

  task automatic send_event(input logic on, input logic [6:0] note);
    wait_ready();
    i_ev_valid = 1'b1; i_ev_on = on; i_ev_note = note;
    @(negedge clk);
    i_ev_valid = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic run_frame();
    for (int k = 0; k < 16; k++) begin f_order[k] = -1; f_midi[k] = 7'h7f; end
    f_count = 0;
    i_tick = 1'b1;
    @(negedge clk);
    i_tick = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (o_clk_en && f_count < 16) begin
        f_order[f_count] = int'(o_slot);
        f_midi[o_slot]   = o_midi;
        f_count++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_tick = 1'b0; i_ev_valid = 1'b0; i_ev_on = 1'b0; i_ev_note = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_clk_en, o_midi, o_slot, o_active, o_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: clk_en=%0b midi=%h slot=%0d active=%h overrun=%0b required all 0",
               o_clk_en, o_midi, o_slot, o_active, o_overrun);
    end
    checks++;
    if (o_ev_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %0b required 1", o_ev_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_empty_frame();
    int bad_order = 0;
    int bad_midi = 0;
    run_frame();
    checks++;
    if (f_count !== NB) begin
      errors++; $display("FAIL empty_frame_count: got %0d required %0d", f_count, NB);
    end
    for (int k = 0; k < NB; k++) begin
      if (f_order[k] != ((k == 0) ? NB - 1 : k - 1)) bad_order++;
      if (f_midi[k] !== 7'd0) bad_midi++;
    end
    checks++;
    if (bad_order != 0) begin
      errors++; $display("FAIL empty_frame_order: %0d wrong slots, first=%0d required 9", bad_order, f_order[0]);
    end
    checks++;
    if (bad_midi != 0) begin
      errors++; $display("FAIL empty_frame_midi: %0d nonzero slots required 0", bad_midi);
    end
    checks++;
    if (o_active !== '0) begin
      errors++; $display("FAIL empty_active: got %h required 000", o_active);
    end
    $display("test_empty_frame: %0d strobes", f_count);
  endtask

  task automatic test_event_latency();
    int ready_hi = 0;
    wait_ready();
    i_ev_valid = 1'b1; i_ev_on = 1'b1; i_ev_note = 7'h45;
    @(negedge clk);
    i_ev_valid = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      if (o_ev_ready) ready_hi++;
      if (n == 11) begin
        checks++;
        if (o_active !== '0) begin
          errors++; $display("FAIL active_early: got %h required 000 at T+11", o_active);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ready_hi != 0) begin
      errors++; $display("FAIL ready_busy: high on %0d cycles required 0", ready_hi);
    end
    checks++;
    if (o_active !== 10'h001) begin
      errors++; $display("FAIL active_note_on: got %h required 001", o_active);
    end
    checks++;
    if (o_ev_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_commit: got %0b required 1", o_ev_ready);
    end
    run_frame();
    checks++;
    if (f_midi[0] !== 7'h45 || f_midi[1] !== 7'h00 || f_midi[9] !== 7'h00) begin
      errors++; $display("FAIL frame_note_45: slot0=%h slot1=%h slot9=%h required 45 00 00",
                         f_midi[0], f_midi[1], f_midi[9]);
    end
    send_event(1'b0, 7'h45);
    checks++;
    if (o_active !== '0) begin
      errors++; $display("FAIL active_note_off: got %h required 000", o_active);
    end
    $display("test_event_latency: note 45 on/off");
  endtask

  task automatic test_retrigger();
    send_event(1'b1, 7'h3C);
    send_event(1'b1, 7'h3C);
    checks++;
    if (o_active !== 10'h001) begin
      errors++; $display("FAIL retrigger_active: got %h required 001", o_active);
    end
    send_event(1'b0, 7'h40);
    checks++;
    if (o_active !== 10'h001) begin
      errors++; $display("FAIL off_not_held: got %h required 001", o_active);
    end
    send_event(1'b1, 7'h00);
    checks++;
    if (o_active !== 10'h001) begin
      errors++; $display("FAIL note_zero: got %h required 001", o_active);
    end
    run_frame();
    checks++;
    if (f_midi[0] !== 7'h3C || f_midi[1] !== 7'h00) begin
      errors++; $display("FAIL retrigger_frame: slot0=%h slot1=%h required 3c 00", f_midi[0], f_midi[1]);
    end
    send_event(1'b0, 7'h3C);
    checks++;
    if (o_active !== '0) begin
      errors++; $display("FAIL retrigger_clear: got %h required 000", o_active);
    end
    $display("test_retrigger: done");
  endtask

  task automatic test_tick_during_search(input logic second, input logic on);
    int ovr = 0;
    int strobes = 0;
    int first = -1;
    logic [6:0] slot0 = 7'h7f;
    wait_ready();
    i_ev_valid = 1'b1; i_ev_on = on; i_ev_note = 7'h22;
    @(negedge clk);
    for (int n = 1; n <= 30; n++) begin
      if (o_overrun) ovr++;
      if (o_clk_en) begin
        strobes++;
        if (first < 0) first = n;
        if (o_slot == 4'd0) slot0 = o_midi;
      end
      if (n == 1) begin i_ev_valid = 1'b0; i_tick = 1'b1; end
      if (n == 2) i_tick = 1'b0;
      if (second && n == 4) i_tick = 1'b1;
      if (n == 5) i_tick = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (ovr != (second ? 1 : 0)) begin
      errors++; $display("FAIL search_overrun: pulses=%0d required %0d", ovr, second ? 1 : 0);
    end
    checks++;
    if (strobes != NB) begin
      errors++; $display("FAIL search_tick_strobes: got %0d required %0d", strobes, NB);
    end
    checks++;
    if (first < 12 || first > 13) begin
      errors++; $display("FAIL search_tick_start: first strobe at T+%0d required after commit (T+12..13)", first);
    end
    checks++;
    if (slot0 !== (on ? 7'h22 : 7'h00)) begin
      errors++; $display("FAIL search_tick_table: slot0=%h required %h", slot0, on ? 7'h22 : 7'h00);
    end
    $display("test_tick_during_search second=%0b: overrun=%0d strobes=%0d first=T+%0d", second, ovr, strobes, first);
  endtask

  task automatic test_steal();
    for (int k = 0; k < NB; k++) send_event(1'b1, 7'(8'h30 + k));
    checks++;
    if (o_active !== 10'h3FF) begin
      errors++; $display("FAIL steal_full: got %h required 3ff", o_active);
    end
    send_event(1'b1, 7'h50);
    run_frame();
    checks++;
    if (f_midi[0] !== 7'h50 || f_midi[1] !== 7'h31 || f_midi[9] !== 7'h39) begin
      errors++; $display("FAIL steal_first: slot0=%h slot1=%h slot9=%h required 50 31 39",
                         f_midi[0], f_midi[1], f_midi[9]);
    end
    send_event(1'b1, 7'h51);
    run_frame();
    checks++;
    if (f_midi[0] !== 7'h50 || f_midi[1] !== 7'h51 || f_midi[2] !== 7'h32) begin
      errors++; $display("FAIL steal_second: slot0=%h slot1=%h slot2=%h required 50 51 32",
                         f_midi[0], f_midi[1], f_midi[2]);
    end
    $display("test_steal: slot0=%h slot1=%h", f_midi[0], f_midi[1]);
  endtask

  task automatic test_scan_overrun();
    int ovr = 0;
    int strobes = 0;
    i_tick = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 20; n++) begin
      if (o_overrun) ovr++;
      if (o_clk_en) strobes++;
      if (n == 1) i_tick = 1'b0;
      if (n == 3) i_tick = 1'b1;
      if (n == 4) i_tick = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (ovr != 1) begin
      errors++; $display("FAIL scan_overrun: pulses=%0d required 1", ovr);
    end
    checks++;
    if (strobes != NB) begin
      errors++; $display("FAIL scan_overrun_strobes: got %0d required %0d", strobes, NB);
    end
    $display("test_scan_overrun: overrun=%0d strobes=%0d", ovr, strobes);
  endtask

  task automatic test_reset_mid_scan();
    int bad_midi = 0;
    i_tick = 1'b1;
    @(negedge clk);
    i_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o_clk_en !== 1'b0 || o_active !== '0) begin
      errors++; $display("FAIL reset_mid_scan: clk_en=%0b active=%h required 0 000", o_clk_en, o_active);
    end
    run_frame();
    checks++;
    if (f_count !== NB || f_order[0] != NB - 1) begin
      errors++; $display("FAIL reset_frame_start: count=%0d first=%0d required 10 9", f_count, f_order[0]);
    end
    for (int k = 0; k < NB; k++) if (f_midi[k] !== 7'd0) bad_midi++;
    checks++;
    if (bad_midi != 0) begin
      errors++; $display("FAIL reset_table: %0d nonzero slots required 0", bad_midi);
    end
    $display("test_reset_mid_scan: first slot %0d", f_order[0]);
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_event_latency();
    test_retrigger();
    test_tick_during_search(1'b0, 1'b1);
    test_tick_during_search(1'b1, 1'b0);
    test_steal();
    test_scan_overrun();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
